// File: rtl/conv_ofm_tx_if.sv
// Handshake and data bundle between the CIM output buffer, the OFM transmit
// block and the next layer's input buffers. The block itself uses the slave
// modport; whatever drives start/data and consumes the pixel uses master.
interface conv_ofm_tx_if #(
  parameter int output_channels = 10,
  parameter int xbar_size       = 256,
  parameter int v_cim_tiles     = 1,
  parameter int h_cim_tiles     = 1,
  parameter int datatype_size   = 8
) ();

  localparam int addr_w = (xbar_size > 1) ? $clog2(xbar_size) : 1;

  logic                                                          i_start;
  logic                                                          i_cim_busy;
  logic                                                          o_busy;
  logic [addr_w-1:0]                                             o_cim_rd_addr;
  logic [v_cim_tiles-1:0][h_cim_tiles-1:0][datatype_size-1:0]    i_data;
  logic                                                          i_next_busy;
  logic [output_channels-1:0]                                    o_ibuf_we;
  logic [output_channels-1:0][datatype_size-1:0]                 o_ibuf_wr_data;

  modport slave (
    input  i_start, i_cim_busy, i_data, i_next_busy,
    output o_busy, o_cim_rd_addr, o_ibuf_we, o_ibuf_wr_data
  );

  modport master (
    output i_start, i_cim_busy, i_data, i_next_busy,
    input  o_busy, o_cim_rd_addr, o_ibuf_we, o_ibuf_wr_data
  );

endinterface

// File: rtl/conv_ofm_tx.sv
// Output feature-map transmitter: reads one completed pixel column by column
// from the CIM output buffer, adds the vertical tiles' partial sums, applies
// saturation (or ReLU + clamp), and writes all channels to the next layer in a
// single write pulse once it can accept them.
// Optional feature: define CONV_OFM_TX_RELU_EN to zero negative sums.
module conv_ofm_tx #(
  parameter int output_channels = 10,
  parameter int xbar_size       = 256,
  parameter int v_cim_tiles     = 1,
  parameter int h_cim_tiles     = 1,
  parameter int datatype_size   = 8
) (
  input logic           clk,
  input logic           rst,
  conv_ofm_tx_if.slave  bus
);

  localparam int addr_w = (xbar_size > 1) ? $clog2(xbar_size) : 1;
  localparam int sum_w  = datatype_size + $clog2(v_cim_tiles) + 1;
  localparam int cols   = (output_channels < xbar_size) ? output_channels : xbar_size;
  localparam logic [addr_w-1:0] last_addr = addr_w'(cols - 1);

  localparam logic signed [sum_w-1:0] sum_max = sum_w'((1 << (datatype_size - 1)) - 1);
  localparam logic signed [datatype_size-1:0] word_max = {1'b0, {(datatype_size-1){1'b1}}};
`ifndef CONV_OFM_TX_RELU_EN
  localparam logic signed [sum_w-1:0] sum_min = sum_w'(-(1 << (datatype_size - 1)));
  localparam logic signed [datatype_size-1:0] word_min = {1'b1, {(datatype_size-1){1'b0}}};
`endif

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WAIT, WRITE} state_t;

  state_t                                        state, state_next;
  logic [addr_w-1:0]                             cnt;
  logic                                          cap_valid;
  logic [addr_w-1:0]                             cap_addr;
  logic                                          busy_q;
  logic [output_channels-1:0][datatype_size-1:0] stored;

  // Sum of all vertical tiles' words for horizontal tile h, sign-extended so
  // the accumulation cannot overflow before saturation.
  function automatic logic signed [sum_w-1:0] tile_sum(
    input logic [v_cim_tiles-1:0][h_cim_tiles-1:0][datatype_size-1:0] d,
    input int h
  );
    logic signed [sum_w-1:0] acc;
    acc = '0;
    for (int v = 0; v < v_cim_tiles; v++) begin
      acc = acc + sum_w'(signed'(d[v][h]));
    end
    return acc;
  endfunction

  // Reduce a wide sum to the pixel range, with optional ReLU.
  function automatic logic signed [datatype_size-1:0] activate(
    input logic signed [sum_w-1:0] s
  );
`ifdef CONV_OFM_TX_RELU_EN
    if (s[sum_w-1])       return '0;
    else if (s > sum_max) return word_max;
    else                  return s[datatype_size-1:0];
`else
    if (s > sum_max)      return word_max;
    else if (s < sum_min) return word_min;
    else                  return s[datatype_size-1:0];
`endif
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:  if (bus.i_start && !bus.i_cim_busy) state_next = READ;
      READ:  if (cnt == last_addr)                state_next = DRAIN;
      DRAIN:                                      state_next = WAIT;
      WAIT:  if (!bus.i_next_busy)                state_next = WRITE;
      WRITE:                                      state_next = IDLE;
      default:                                    state_next = IDLE;
    endcase
  end

  // Column counter and the one-cycle-delayed capture strobe/address that
  // line up with the buffer's read latency.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      cnt       <= '0;
      cap_valid <= 1'b0;
      cap_addr  <= '0;
      busy_q    <= 1'b0;
    end else begin
      cnt       <= (state == READ) ? cnt + 1'b1 : '0;
      cap_valid <= (state == READ);
      cap_addr  <= cnt;
      busy_q    <= (state_next != IDLE);
    end
  end

  // Pixel store: each channel latches when its column comes back; channels
  // beyond output_channels on the last tile simply have no register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the store is reset because an aborted pixel must read back as zero.
    if (rst) begin
      stored <= '0;
    end else if (cap_valid) begin
      for (int c = 0; c < output_channels; c++) begin
        if (cap_addr == addr_w'(c % xbar_size))
          stored[c] <= activate(tile_sum(bus.i_data, c / xbar_size));
      end
    end
  end

  assign bus.o_busy         = busy_q;
  assign bus.o_cim_rd_addr  = (state == READ) ? cnt : '0;
  assign bus.o_ibuf_we      = {output_channels{state == WRITE}};
  assign bus.o_ibuf_wr_data = stored;

endmodule
